// File: rtl/fdc_bridge_pkg.sv
// Shared types and constants for the u765 SD-buffer sector bridge.
package fdc_bridge_pkg;

  localparam int unsigned SECTOR_BYTES = 512;
  localparam int unsigned SECTOR_SHIFT = 9;
  localparam logic [8:0]  LAST_IDX     = 9'd511;

  typedef enum logic [3:0] {
    StIdle,
    StRdReq,
    StRdWait,
    StRdPut,
    StWrFetch,
    StWrReq,
    StWrWait,
    StWrNext,
    StDone
  } bridge_state_t;

endpackage

// File: rtl/fdc_sd_bridge_if.sv
// Controller sector-buffer port plus byte-wide image-memory port of the bridge.
interface fdc_sd_bridge_if #(
  parameter int unsigned MEM_AW = 24
);

  logic [31:0]       sd_lba;
  logic [1:0]        sd_rd;
  logic [1:0]        sd_wr;
  logic              sd_ack;
  logic [8:0]        sd_buff_addr;
  logic [7:0]        sd_buff_dout;
  logic              sd_buff_wr;
  logic [7:0]        sd_buff_din;

  logic [MEM_AW-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              mem_ready;

  // The bridge side: answers controller requests and masters the image memory.
  modport master (
    input  sd_lba, sd_rd, sd_wr, sd_buff_din, mem_rdata, mem_ready,
    output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
    output mem_addr, mem_rd, mem_wr, mem_wdata
  );

  modport slave (
    output sd_lba, sd_rd, sd_wr, sd_buff_din, mem_rdata, mem_ready,
    input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
    input  mem_addr, mem_rd, mem_wr, mem_wdata
  );

endinterface

// File: rtl/fdc_img_table.sv
// Per-drive image-size latch and sector range check for a candidate request.
module fdc_img_table
  import fdc_bridge_pkg::*;
(
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [1:0]  img_mounted,
  input  logic [31:0] img_size,
  input  logic        drv,
  input  logic [31:0] lba,
  output logic        valid
);

  logic [31:0] size_q [2];
  logic [31:0] drv_size;
  logic [41:0] sec_end;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      size_q[0] <= '0;
      size_q[1] <= '0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (img_mounted[d]) size_q[d] <= img_size;
      end
    end
  end

  // Wide enough that lba = 32'hFFFF_FFFF cannot wrap into a small end offset.
  always_comb begin
    drv_size = size_q[drv];
    sec_end  = (42'(lba) + 42'd1) * 42'(SECTOR_BYTES);
    valid    = (drv_size != '0) && (sec_end <= 42'(drv_size));
  end

endmodule

// File: rtl/fdc_sd_bridge.sv
// Streams 512-byte sectors between the u765 SD-buffer port and a byte-wide image memory.
module fdc_sd_bridge
  import fdc_bridge_pkg::*;
#(
  parameter int unsigned MEM_AW      = 24,
  parameter int unsigned DRIVE1_BASE = 32'h0040_0000
) (
  input  logic            clk_sys,
  input  logic            reset_n,
  input  logic [1:0]      img_mounted,
  input  logic [31:0]     img_size,
  fdc_sd_bridge_if.master bus,
  output logic            busy
);

  bridge_state_t     state_q, state_d;
  logic [MEM_AW-1:0] start_q, start_d;
  logic [8:0]        idx_q, idx_d;
  logic              valid_q, valid_d;
  logic [7:0]        data_q, data_d;
  logic [7:0]        wdata_q, wdata_d;

  logic              req_any;
  logic              req_drv;
  logic              req_wr;
  logic              tbl_valid;
  logic [MEM_AW-1:0] req_start;

  // Fixed priority: rd0, wr0, rd1, wr1.
  always_comb begin
    req_any = |{bus.sd_rd, bus.sd_wr};
    req_drv = 1'b1;
    req_wr  = 1'b1;
    if (bus.sd_rd[0]) begin
      req_drv = 1'b0;
      req_wr  = 1'b0;
    end else if (bus.sd_wr[0]) begin
      req_drv = 1'b0;
      req_wr  = 1'b1;
    end else if (bus.sd_rd[1]) begin
      req_drv = 1'b1;
      req_wr  = 1'b0;
    end
    req_start = (req_drv ? MEM_AW'(DRIVE1_BASE) : '0)
              + MEM_AW'(42'(bus.sd_lba) << SECTOR_SHIFT);
  end

  fdc_img_table u_img_table (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .img_mounted (img_mounted),
    .img_size    (img_size),
    .drv         (req_drv),
    .lba         (bus.sd_lba),
    .valid       (tbl_valid)
  );

  always_comb begin
    state_d = state_q;
    start_d = start_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    data_d  = data_q;
    wdata_d = wdata_q;
    unique case (state_q)
      StIdle: begin
        if (req_any) begin
          start_d = req_start;
          idx_d   = '0;
          valid_d = tbl_valid;
          state_d = req_wr ? StWrFetch : StRdReq;
        end
      end
      StRdReq: begin
        if (valid_q) begin
          state_d = StRdWait;
        end else begin
          data_d  = 8'h00;
          state_d = StRdPut;
        end
      end
      StRdWait: begin
        if (bus.mem_ready) begin
          data_d  = bus.mem_rdata;
          state_d = StRdPut;
        end
      end
      StRdPut: begin
        if (idx_q == LAST_IDX) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + 9'd1;
          state_d = StRdReq;
        end
      end
      StWrFetch: state_d = StWrReq;
      StWrReq: begin
        wdata_d = bus.sd_buff_din;
        state_d = valid_q ? StWrWait : StWrNext;
      end
      StWrWait: begin
        if (bus.mem_ready) state_d = StWrNext;
      end
      StWrNext: begin
        if (idx_q == LAST_IDX) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + 9'd1;
          state_d = StWrFetch;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      start_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      wdata_q <= wdata_d;
    end
  end

  // Outputs decode from registers only, so reset clears them without waiting for a clock.
  always_comb begin
    bus.sd_ack       = (state_q != StIdle) && (state_q != StDone);
    busy             = (state_q != StIdle);
    bus.sd_buff_addr = idx_q;
    bus.sd_buff_dout = data_q;
    bus.sd_buff_wr   = (state_q == StRdPut);
    bus.mem_addr     = start_q + MEM_AW'(idx_q);
    bus.mem_rd       = (state_q == StRdWait);
    bus.mem_wr       = (state_q == StWrWait);
    bus.mem_wdata    = wdata_q;
  end

endmodule

// File: tb/tb_fdc_sd_bridge.sv
// Randomized bench for fdc_sd_bridge against a sector-level reference model.
module tb_fdc_sd_bridge;

  localparam int unsigned MEM_AW  = 24;
  localparam int unsigned D1_BASE = 32'h0040_0000;
  localparam int unsigned AMASK   = (1 << MEM_AW) - 1;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  img_mounted = 2'b00;
  logic [31:0] img_size = '0;
  logic        busy;

  fdc_sd_bridge_if #(.MEM_AW(MEM_AW)) bus ();

  fdc_sd_bridge #(
    .MEM_AW      (MEM_AW),
    .DRIVE1_BASE (D1_BASE)
  ) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .img_mounted (img_mounted),
    .img_size    (img_size),
    .bus         (bus.master),
    .busy        (busy)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic [31:0] a;
    logic [7:0]  d;
  } ev_t;

  int unsigned sz_m [2];
  logic [7:0]  mem_w [int unsigned];
  logic [7:0]  buf_m [512];
  ev_t         rd_log [$];
  ev_t         wr_log [$];
  ev_t         bw_log [$];
  int unsigned dly_q [$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          stab_err = 0;
  int          hold_at = -1;
  int unsigned last_addr = 0;

  logic              in_cyc = 1'b0;
  int unsigned       cnt = 0;
  logic [MEM_AW-1:0] h_addr;
  logic [7:0]        h_wdata;

  function automatic logic [7:0] mem_byte(input int unsigned a);
    if (mem_w.exists(a)) return mem_w[a];
    return 8'(a ^ (a >> 8) ^ (a >> 16)) ^ 8'h5A;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Image memory with random 0..7 cycle stalls, and the controller's sector buffer.
  always @(negedge clk_sys) begin
    bus.mem_ready   = 1'b0;
    bus.sd_buff_din = buf_m[last_addr];
    last_addr       = 32'(bus.sd_buff_addr);
    if (!reset_n) begin
      in_cyc = 1'b0;
    end else begin
      if (bus.sd_buff_wr) bw_log.push_back(ev_t'{a: 32'(bus.sd_buff_addr), d: bus.sd_buff_dout});
      if (bus.mem_rd && bus.mem_wr) stab_err++;
      if (bus.mem_rd || bus.mem_wr) begin
        if (!in_cyc) begin
          in_cyc  = 1'b1;
          cnt     = $urandom_range(0, 7);
          dly_q.push_back(cnt);
          h_addr  = bus.mem_addr;
          h_wdata = bus.mem_wdata;
        end else if (bus.mem_addr != h_addr || (bus.mem_wr && bus.mem_wdata != h_wdata)) begin
          stab_err++;
        end
        if (cnt == 0 && !(hold_at >= 0 && rd_log.size() == hold_at)) begin
          bus.mem_ready = 1'b1;
          in_cyc        = 1'b0;
          if (bus.mem_rd) begin
            bus.mem_rdata = mem_byte(32'(bus.mem_addr));
            rd_log.push_back(ev_t'{a: 32'(bus.mem_addr), d: bus.mem_rdata});
          end else begin
            mem_w[32'(bus.mem_addr)] = bus.mem_wdata;
            wr_log.push_back(ev_t'{a: 32'(bus.mem_addr), d: bus.mem_wdata});
          end
        end else if (cnt != 0) begin
          cnt--;
        end
      end
    end
  end

  task automatic mount(input logic [1:0] m, input logic [31:0] sz);
    @(negedge clk_sys);
    img_mounted = m;
    img_size    = sz;
    @(negedge clk_sys);
    img_mounted = 2'b00;
    if (m[0]) sz_m[0] = sz;
    if (m[1]) sz_m[1] = sz;
  endtask

  task automatic issue(input logic [1:0] rd, input logic [1:0] wr, input logic [31:0] lba);
    @(negedge clk_sys);
    bus.sd_lba = lba;
    bus.sd_rd  = rd;
    bus.sd_wr  = wr;
  endtask

  task automatic check_zero(input string p);
    check_eq({p, "_sd_ack"}, bus.sd_ack, 0);
    check_eq({p, "_buff_addr"}, bus.sd_buff_addr, 0);
    check_eq({p, "_buff_dout"}, bus.sd_buff_dout, 0);
    check_eq({p, "_buff_wr"}, bus.sd_buff_wr, 0);
    check_eq({p, "_mem_addr"}, bus.mem_addr, 0);
    check_eq({p, "_mem_rd"}, bus.mem_rd, 0);
    check_eq({p, "_mem_wr"}, bus.mem_wr, 0);
    check_eq({p, "_mem_wdata"}, bus.mem_wdata, 0);
    check_eq({p, "_busy"}, busy, 0);
  endtask

  // Follows one transfer from acknowledge to idle and checks it against the sector model.
  task automatic serve(input bit d, input bit wr, input logic [31:0] lba, input bit fresh);
    int                cyc;
    int                bad;
    int                n_exp;
    bit                v;
    int unsigned       base;
    longint unsigned   exp_cyc;
    longint unsigned   sec_end;
    logic [7:0]        exp_d;
    sec_end = ({32'd0, lba} + 64'd1) * 64'd512;
    v       = (sz_m[d] != 0) && (sec_end <= 64'(sz_m[d]));
    base    = ((d ? D1_BASE : 32'd0) + (lba << 9)) & AMASK;
    @(negedge clk_sys);
    if (!fresh) begin
      for (int k = 0; k < 6 && !bus.sd_ack; k++) @(negedge clk_sys);
    end
    check_eq("ack_rise", bus.sd_ack, 1);
    rd_log.delete();
    wr_log.delete();
    bw_log.delete();
    dly_q.delete();
    stab_err = 0;
    if (wr) bus.sd_wr[d] = 1'b0;
    else bus.sd_rd[d] = 1'b0;
    cyc = 0;
    while (bus.sd_ack && cyc < 12000) begin
      cyc++;
      @(negedge clk_sys);
    end
    check_eq("ack_fall", bus.sd_ack, 0);
    check_eq("busy_in_done", busy, 1);
    exp_cyc = 0;
    if (v) foreach (dly_q[i]) exp_cyc += 64'(dly_q[i]) + (wr ? 64'd4 : 64'd3);
    else exp_cyc = wr ? 64'd1536 : 64'd1024;
    check_eq("ack_cycles", cyc, exp_cyc);
    n_exp = v ? 512 : 0;
    if (wr) begin
      check_eq("mem_wr_count", wr_log.size(), n_exp);
      check_eq("mem_rd_in_write", rd_log.size(), 0);
      check_eq("buff_wr_in_write", bw_log.size(), 0);
      bad = 0;
      foreach (wr_log[i]) begin
        if (i >= 512 || wr_log[i].a != ((base + i) & AMASK) || wr_log[i].d != buf_m[i]) bad++;
      end
      check_eq("mem_wr_data", bad, 0);
    end else begin
      check_eq("mem_rd_count", rd_log.size(), n_exp);
      check_eq("mem_wr_in_read", wr_log.size(), 0);
      check_eq("buff_wr_count", bw_log.size(), 512);
      bad = 0;
      foreach (rd_log[i]) if (rd_log[i].a != ((base + i) & AMASK)) bad++;
      check_eq("mem_rd_addr", bad, 0);
      bad = 0;
      foreach (bw_log[i]) begin
        exp_d = v ? mem_byte((base + i) & AMASK) : 8'h00;
        if (bw_log[i].a != i || bw_log[i].d != exp_d) bad++;
      end
      check_eq("buff_data", bad, 0);
    end
    check_eq("strobe_stable", stab_err, 0);
    @(negedge clk_sys);
    check_eq("busy_idle", busy, 0);
  endtask

  initial begin
    #1_200_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bit rd_d, rd_w;
    logic [31:0] r_lba, r_sz;
    bus.sd_rd  = '0;
    bus.sd_wr  = '0;
    bus.sd_lba = '0;
    sz_m[0] = 0;
    sz_m[1] = 0;
    foreach (buf_m[i]) buf_m[i] = 8'($urandom);
    repeat (3) @(negedge clk_sys);
    check_zero("reset");
    reset_n = 1'b1;

    mount(2'b01, 32'd184320);
    issue(2'b01, 2'b00, 32'd3);
    serve(1'b0, 1'b0, 32'd3, 1'b1);

    issue(2'b00, 2'b10, 32'd0);
    serve(1'b1, 1'b1, 32'd0, 1'b1);

    mount(2'b01, 32'd1024);
    issue(2'b01, 2'b00, 32'd2);
    serve(1'b0, 1'b0, 32'd2, 1'b1);

    // lba 1 ends exactly at the 1024-byte image end; drive 1 is still unmounted.
    issue(2'b11, 2'b01, 32'd1);
    serve(1'b0, 1'b0, 32'd1, 1'b1);
    serve(1'b0, 1'b1, 32'd1, 1'b0);
    serve(1'b1, 1'b0, 32'd1, 1'b0);

    foreach (buf_m[i]) buf_m[i] = 8'(i * 3 + 1);
    mount(2'b10, 32'h0010_0000);
    issue(2'b00, 2'b10, 32'd0);
    serve(1'b1, 1'b1, 32'd0, 1'b1);

    mount(2'b01, 32'd184320);
    hold_at = 100;
    issue(2'b01, 2'b00, 32'd5);
    @(negedge clk_sys);
    check_eq("rst_ack_rise", bus.sd_ack, 1);
    bus.sd_rd = 2'b00;
    k = 0;
    while (!(bus.mem_rd && rd_log.size() == 100) && k < 2000) begin
      k++;
      @(negedge clk_sys);
    end
    check_eq("stall_reached", rd_log.size(), 100);
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b0;
    #1;
    check_zero("rst_mid");
    hold_at = -1;
    sz_m[0] = 0;
    sz_m[1] = 0;
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
    issue(2'b01, 2'b00, 32'd0);
    serve(1'b0, 1'b0, 32'd0, 1'b1);
    mount(2'b01, 32'd184320);
    issue(2'b01, 2'b00, 32'd9);
    serve(1'b0, 1'b0, 32'd9, 1'b1);

    for (int t = 0; t < 6; t++) begin
      rd_d = 1'($urandom);
      rd_w = 1'($urandom);
      if (t == 0 || $urandom_range(0, 2) == 0) begin
        r_sz = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(512, 400000));
        mount(rd_d ? 2'b10 : (($urandom_range(0, 3) == 0) ? 2'b11 : 2'b01), r_sz);
      end
      case ($urandom_range(0, 3))
        0:       r_lba = sz_m[rd_d] / 512 - 1;
        1:       r_lba = sz_m[rd_d] / 512;
        2:       r_lba = $urandom_range(0, 800);
        default: r_lba = 32'hFFFF_FFFF;
      endcase
      if (rd_w) foreach (buf_m[i]) buf_m[i] = 8'($urandom);
      issue(rd_w ? 2'b00 : (rd_d ? 2'b10 : 2'b01), rd_w ? (rd_d ? 2'b10 : 2'b01) : 2'b00, r_lba);
      serve(rd_d, rd_w, r_lba, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
